// File: rtl/dmem_responder_pkg.sv
// ----------------------------------------------------------------------------
// Pipe_Buf_Reg_PKG
// Shared definitions for the data-memory responder:
//   - dmem_state_e : responder FSM states (IDLE, WAIT, RESP)
//   - F3_*         : RV32I load/store funct3 encodings
//   - SZ_*         : access size taken from funct3[1:0]
//   - f3_legal()   : is the funct3 / kind combination a supported access
//   - misaligned() : does the access cross its natural alignment
// ----------------------------------------------------------------------------
package Pipe_Buf_Reg_PKG;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size in funct3[1:0]
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // A request is legal only when exactly one of load/store is set and the
  // funct3 is one this responder implements for that kind.
  function automatic logic f3_legal(input logic is_wr, input logic is_rd,
                                    input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (is_rd && !is_wr) begin
      case (f3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
        default:                             ok = 1'b0;
      endcase
    end else if (is_wr && !is_rd) begin
      case (f3)
        F3_SB, F3_SH, F3_SW: ok = 1'b1;
        default:             ok = 1'b0;
      endcase
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0. Because aligned
  // accesses never straddle the top of memory, this also rules out wrap.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    case (f3[1:0])
      SZ_HALF: bad = a[0];
      SZ_WORD: bad = (a != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_responder_lane_align.sv
// ----------------------------------------------------------------------------
// dmem_lane_align
// Combinational load-extract / store byte-merge for the data memory.
// Ports:
//   funct3_i  : access size/sign (RV32I encoding)
//   addr_lo_i : low two address bits (alignment check)
//   is_wr_i   : store request
//   is_rd_i   : load request
//   wdata_i   : store data, low-aligned
//   win_i     : 4-byte little-endian window read starting at the address
//   rdata_o   : extended load result (0 for stores and faulted accesses)
//   merged_o  : window with the store bytes merged in
//   be_o      : bytes of the window to write (0 for loads and faults)
//   err_o     : access is faulted
// ----------------------------------------------------------------------------
module dmem_lane_align
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic              is_wr_i,
  input  logic              is_rd_i,
  input  logic [31:0]       wdata_i,
  input  logic [31:0]       win_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [31:0]       merged_o,
  output logic [3:0]        be_o,
  output logic              err_o
);

  logic err_s;

  // Fault detection, load extension and store byte enables.
  always_comb begin
    err_s    = !f3_legal(is_wr_i, is_rd_i, funct3_i) || misaligned(funct3_i, addr_lo_i);
    rdata_o  = '0;
    be_o     = 4'b0000;
    merged_o = win_i;
    if (!err_s) begin
      if (is_rd_i) begin
        case (funct3_i)
          F3_LB:   rdata_o = DATA_W'($signed(win_i[7:0]));
          F3_LH:   rdata_o = DATA_W'($signed(win_i[15:0]));
          F3_LW:   rdata_o = DATA_W'(win_i);
          F3_LBU:  rdata_o = DATA_W'(win_i[7:0]);
          F3_LHU:  rdata_o = DATA_W'(win_i[15:0]);
          default: rdata_o = '0;
        endcase
      end else begin
        case (funct3_i[1:0])
          SZ_BYTE: be_o = 4'b0001;
          SZ_HALF: be_o = 4'b0011;
          SZ_WORD: be_o = 4'b1111;
          default: be_o = 4'b0000;
        endcase
      end
    end else begin
      rdata_o = '0;
      be_o    = 4'b0000;
    end
    for (int k = 0; k < 4; k++) begin
      merged_o[8*k +: 8] = be_o[k] ? wdata_i[8*k +: 8] : win_i[8*k +: 8];
    end
  end

  assign err_o = err_s;

endmodule

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Byte-addressed little-endian data memory with a fixed-latency handshake
// (IDLE -> WAIT x WAIT_CYC -> RESP) for the pipeline MEM stage.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   req_valid  : request present
//   req_wr     : store request
//   req_rd     : load request
//   req_addr   : byte address
//   req_wdata  : store data, low-aligned
//   req_funct3 : RV32I access size/sign
//   req_ready  : responder idle
//   resp_valid : one-cycle completion pulse
//   resp_rdata : load result (0 for stores/faults and outside resp_valid)
//   resp_err   : completion faulted (0 outside resp_valid)
//   mem_stall  : hold the pipeline until completion
// DATA_W must be at least 32; only the low 32 bits of store data are used.
// ----------------------------------------------------------------------------
module dmem_responder
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int WAIT_CYC   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_wr,
  input  logic                  req_rd,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  mem_stall
);

  localparam int         MEM_BYTES = 1 << DM_ADDRESS;
  localparam logic [2:0] LAST_CNT  = 3'(WAIT_CYC - 1);

  logic [7:0]            mem_q [MEM_BYTES];

  dmem_state_e           state_q;
  logic [2:0]            cnt_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [2:0]            f3_q;
  logic                  wr_q;
  logic                  rd_q;
  logic                  resp_valid_q;
  logic [DATA_W-1:0]     resp_rdata_q;
  logic                  resp_err_q;

  logic                  in_idle_s;
  logic                  go_s;
  logic                  enter_resp_s;
  logic                  mem_we_s;
  logic [DM_ADDRESS-1:0] addr_s;
  logic [DATA_W-1:0]     wdata_s;
  logic [2:0]            f3_s;
  logic                  wr_s;
  logic                  rd_s;
  logic [31:0]           win_s;
  logic [DATA_W-1:0]     align_rdata_s;
  logic [31:0]           merged_s;
  logic [3:0]            be_s;
  logic                  align_err_s;

  assign in_idle_s = (state_q == ST_IDLE);
  assign go_s      = req_valid & (req_wr | req_rd);

  // With zero wait states the access completes straight out of IDLE, so the
  // aligner must look at the live request there and at the latched copy
  // otherwise.
  assign addr_s  = in_idle_s ? req_addr   : addr_q;
  assign wdata_s = in_idle_s ? req_wdata  : wdata_q;
  assign f3_s    = in_idle_s ? req_funct3 : f3_q;
  assign wr_s    = in_idle_s ? req_wr     : wr_q;
  assign rd_s    = in_idle_s ? req_rd     : rd_q;

  // The edge that moves the FSM into RESP is the only commit point.
  assign enter_resp_s = ((WAIT_CYC == 0) && in_idle_s && go_s) ||
                        ((state_q == ST_WAIT) && (cnt_q == LAST_CNT));
  // Gate with reset so a store pending when reset asserts never lands.
  assign mem_we_s     = reset & enter_resp_s;

  // Four-byte read window starting at the access address; bytes beyond the
  // top address wrap but are only ever consumed by aligned accesses.
  always_comb begin
    win_s = '0;
    for (int k = 0; k < 4; k++) begin
      win_s[8*k +: 8] = mem_q[addr_s + DM_ADDRESS'(k)];
    end
  end

  dmem_lane_align #(
    .DATA_W (DATA_W)
  ) u_lane_align (
    .funct3_i  (f3_s),
    .addr_lo_i (addr_s[1:0]),
    .is_wr_i   (wr_s),
    .is_rd_i   (rd_s),
    .wdata_i   (wdata_s[31:0]),
    .win_i     (win_s),
    .rdata_o   (align_rdata_s),
    .merged_o  (merged_s),
    .be_o      (be_s),
    .err_o     (align_err_s)
  );

  // Byte array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int k = 0; k < 4; k++) begin
        if (be_s[k]) begin
          mem_q[addr_s + DM_ADDRESS'(k)] <= merged_s[8*k +: 8];
        end
      end
    end
  end

  // Responder FSM with wait counter, request latch and registered response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      f3_q         <= 3'd0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
          cnt_q        <= 3'd0;
          if (go_s) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            f3_q    <= req_funct3;
            wr_q    <= req_wr;
            rd_q    <= req_rd;
            if (WAIT_CYC == 0) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= align_rdata_s;
              resp_err_q   <= align_err_s;
            end else begin
              state_q <= ST_WAIT;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt_q == LAST_CNT) begin
            state_q      <= ST_RESP;
            cnt_q        <= 3'd0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= align_rdata_s;
            resp_err_q   <= align_err_s;
          end else begin
            state_q <= ST_WAIT;
            cnt_q   <= cnt_q + 3'd1;
          end
        end
        ST_RESP: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
        end
        default: begin
          state_q      <= ST_IDLE;
          cnt_q        <= 3'd0;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = in_idle_s;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  // Stall must rise in the request cycle itself, hence the live term.
  assign mem_stall  = reset & ((in_idle_s & go_s) | (state_q == ST_WAIT));

endmodule
